// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction-fetch responder.
// Provides the FSM state encoding and the instruction address / instruction
// widths used by the responder and by anything that talks to it.
package inst_fetch_responder_pkg;

    localparam int INSTRUCTION_ADDRESS_SIZE = 32;
    localparam int INSTRUCTION_SIZE         = 32;
    localparam int INSTRUCTION_BYTES        = 4;

    typedef enum logic [1:0] {
        IFR_IDLE  = 2'd0,
        IFR_FETCH = 2'd1,
        IFR_RESP  = 2'd2
    } ifr_state_e;

endpackage

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder (memory-controller side of the IF miss path).
// Takes a word-fetch request, reads the four bytes of the aligned word over a
// byte-wide RAM port (1-cycle read latency, arbitrated by mem_ready), assembles
// them little-endian and returns the word with a one-cycle completion pulse.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   instruction_read_flag      IF request level (held while IF stalls)
//   instruction_read_address   requested instruction address
//   _instruction_flag          one-cycle pulse: _instruction is valid
//   _instruction_read_address  echoed request address (unmodified)
//   _instruction               assembled 32-bit instruction
//   mem_ready                  RAM port granted this cycle
//   mem_re, mem_a              byte read strobe and byte address
//   mem_din                    RAM read data, valid the cycle after issue
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTRUCTION_ADDRESS_SIZE,
    parameter int INST_BYTES = INSTRUCTION_BYTES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instruction_read_flag,
    input  logic [ADDR_WIDTH-1:0]       instruction_read_address,
    output logic                        _instruction_flag,
    output logic [ADDR_WIDTH-1:0]       _instruction_read_address,
    output logic [INSTRUCTION_SIZE-1:0] _instruction,
    input  logic                        mem_ready,
    output logic                        mem_re,
    output logic [ADDR_WIDTH-1:0]       mem_a,
    input  logic [7:0]                  mem_din
);

    localparam logic [2:0] NBYTES = 3'(INST_BYTES);

    ifr_state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]       base_q, base_d;
    logic [ADDR_WIDTH-1:0]       req_addr_q, req_addr_d;
    logic [2:0]                  issue_cnt_q, issue_cnt_d;
    logic [2:0]                  recv_cnt_q, recv_cnt_d;
    logic                        pend_valid_q, pend_valid_d;
    logic [1:0]                  pend_idx_q, pend_idx_d;
    logic [7:0]                  byte_buf_q [4];
    logic [7:0]                  byte_buf_d [4];
    logic                        inst_flag_q, inst_flag_d;
    logic [ADDR_WIDTH-1:0]       inst_addr_q, inst_addr_d;
    logic [INSTRUCTION_SIZE-1:0] inst_q, inst_d;
    logic                        abort;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        req_addr_d   = req_addr_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        // A byte is in flight only if it was issued this very cycle.
        pend_valid_d = 1'b0;
        pend_idx_d   = pend_idx_q;
        byte_buf_d   = byte_buf_q;
        inst_flag_d  = 1'b0;
        inst_addr_d  = inst_addr_q;
        inst_d       = inst_q;
        mem_re       = 1'b0;
        mem_a        = '0;
        abort        = 1'b0;

        case (state_q)
            IFR_IDLE: begin
                if (instruction_read_flag) begin
                    base_d      = {instruction_read_address[ADDR_WIDTH-1:2], 2'b00};
                    req_addr_d  = instruction_read_address;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = IFR_FETCH;
                end
            end

            IFR_FETCH: begin
                // IF dropped the miss or redirected: abandon the word, and any
                // byte still in flight is discarded with it.
                abort = !instruction_read_flag || (instruction_read_address != req_addr_q);
                if (abort) begin
                    state_d = IFR_IDLE;
                end else begin
                    if ((issue_cnt_q < NBYTES) && mem_ready) begin
                        mem_re       = 1'b1;
                        mem_a        = base_q + {{(ADDR_WIDTH-3){1'b0}}, issue_cnt_q};
                        pend_valid_d = 1'b1;
                        pend_idx_d   = issue_cnt_q[1:0];
                        issue_cnt_d  = issue_cnt_q + 3'd1;
                    end
                    if (pend_valid_q) begin
                        byte_buf_d[pend_idx_q] = mem_din;
                        recv_cnt_d             = recv_cnt_q + 3'd1;
                        // Last byte lands now: load the response registers
                        // so the pulse coincides with the RESP state.
                        if (recv_cnt_q == NBYTES - 3'd1) begin
                            state_d     = IFR_RESP;
                            inst_flag_d = 1'b1;
                            inst_addr_d = req_addr_q;
                            inst_d      = {byte_buf_d[3], byte_buf_d[2],
                                           byte_buf_d[1], byte_buf_d[0]};
                        end
                    end
                end
            end

            IFR_RESP: begin
                state_d = IFR_IDLE;
            end

            default: begin
                state_d = IFR_IDLE;
            end
        endcase

        if (rst) begin
            mem_re = 1'b0;
            mem_a  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IFR_IDLE;
            base_q       <= '0;
            req_addr_q   <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                byte_buf_q[i] <= '0;
            end
            inst_flag_q  <= 1'b0;
            inst_addr_q  <= '0;
            inst_q       <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            req_addr_q   <= req_addr_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            byte_buf_q   <= byte_buf_d;
            inst_flag_q  <= inst_flag_d;
            inst_addr_q  <= inst_addr_d;
            inst_q       <= inst_d;
        end
    end

    assign _instruction_flag         = inst_flag_q;
    assign _instruction_read_address = inst_addr_q;
    assign _instruction              = inst_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: byte RAM model, scoreboard of
// expected RAM issue addresses and expected responses (with due cycle).
module tb_inst_fetch_responder;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_flag;
    logic [AW-1:0] req_addr;
    logic          out_flag;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_inst;
    logic          mem_ready;
    logic          mem_re;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_din = 8'h00;

    inst_fetch_responder #(.ADDR_WIDTH(AW), .INST_BYTES(4)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .instruction_read_flag     (req_flag),
        .instruction_read_address  (req_addr),
        ._instruction_flag         (out_flag),
        ._instruction_read_address (out_addr),
        ._instruction              (out_inst),
        .mem_ready                 (mem_ready),
        .mem_re                    (mem_re),
        .mem_a                     (mem_a),
        .mem_din                   (mem_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM with 1-cycle read latency.
    logic [7:0] ram [0:4095];
    always @(posedge clk) mem_din <= mem_re ? ram[mem_a[11:0]] : 8'h00;

    typedef struct {
        logic [31:0]   inst;
        logic [AW-1:0] addr;
        int            due;
    } resp_t;

    logic [AW-1:0] issue_q [$];
    resp_t         resp_q  [$];
    int n_checks = 0;
    int n_fail   = 0;
    int issues_seen = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every issued byte address and every response pulse is matched
    // against the scoreboard.
    always @(negedge clk) begin
        if (mem_re === 1'b1) begin
            issues_seen++;
            check_eq("issue_expected", 64'(issue_q.size() != 0), 64'd1);
            if (issue_q.size() != 0) begin
                logic [AW-1:0] ea;
                ea = issue_q.pop_front();
                check_eq("mem_a", 64'(mem_a), 64'(ea));
            end
        end
        if (out_flag === 1'b1) begin
            check_eq("resp_expected", 64'(resp_q.size() != 0), 64'd1);
            if (resp_q.size() != 0) begin
                resp_t r;
                r = resp_q.pop_front();
                check_eq("inst", 64'(out_inst), 64'(r.inst));
                check_eq("resp_addr", 64'(out_addr), 64'(r.addr));
                check_eq("latency_cycle", 64'(cyc), 64'(r.due));
            end
        end
    end

    task automatic push_issues(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] b;
        b = {a[AW-1:2], 2'b00};
        for (int i = 0; i < n; i++) issue_q.push_back(b + AW'(i));
    endtask

    task automatic push_word(input logic [AW-1:0] a, input int due);
        logic [11:0] b;
        resp_t r;
        push_issues(a, 4);
        b = {a[11:2], 2'b00};
        r.inst = {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
        r.addr = a;
        r.due  = due;
        resp_q.push_back(r);
    endtask

    // Returns at the falling edge of the cycle in which the pulse is visible.
    task automatic wait_flag(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_flag !== 1'b1 && n < 60);
        if (out_flag !== 1'b1) check_eq({tag, "_timeout"}, 64'(out_flag), 64'd1);
    endtask

    task automatic wait_issues(input int target);
        int n = 0;
        while (issues_seen < target && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (issues_seen < target) check_eq("issue_timeout", 64'(issues_seen), 64'(target));
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'((i * 37 + 11) ^ (i >> 4));
        ram[12'h100] = 8'h13;
        ram[12'h101] = 8'h05;
        ram[12'h102] = 8'hA0;
        ram[12'h103] = 8'h00;

        rst = 1'b1; req_flag = 1'b0; req_addr = '0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_flag", 64'(out_flag), 64'd0);
        check_eq("rst_addr", 64'(out_addr), 64'd0);
        check_eq("rst_inst", 64'(out_inst), 64'd0);
        check_eq("rst_mem_re", 64'(mem_re), 64'd0);
        check_eq("rst_mem_a", 64'(mem_a), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic fetch
        idle(1);
        req_flag = 1'b1; req_addr = 32'h100; push_word(32'h100, cyc + 6);
        wait_flag("basic");
        check_eq("basic_word", 64'(out_inst), 64'h00A00513);
        req_flag = 1'b0;

        // Backpressure: two stall cycles after the second issue
        idle(2);
        n0 = issues_seen;
        req_flag = 1'b1; req_addr = 32'h100; push_word(32'h100, cyc + 8);
        wait_issues(n0 + 2);
        mem_ready = 1'b0;
        idle(1);
        idle(1);
        mem_ready = 1'b1;
        wait_flag("stall");
        req_flag = 1'b0;

        // Redirect after two issues
        idle(2);
        n0 = issues_seen;
        req_flag = 1'b1; req_addr = 32'h100; push_issues(32'h100, 2);
        wait_issues(n0 + 2);
        req_addr = 32'h200; push_word(32'h200, cyc + 7);
        wait_flag("redirect");
        req_flag = 1'b0;

        // Reset one cycle after the third issue
        idle(2);
        n0 = issues_seen;
        req_flag = 1'b1; req_addr = 32'h300; push_issues(32'h300, 3);
        wait_issues(n0 + 3);
        rst = 1'b1; req_flag = 1'b0;
        @(negedge clk);
        check_eq("midrst_mem_re", 64'(mem_re), 64'd0);
        check_eq("midrst_mem_a", 64'(mem_a), 64'd0);
        @(negedge clk);
        check_eq("midrst_flag", 64'(out_flag), 64'd0);
        check_eq("midrst_addr", 64'(out_addr), 64'd0);
        check_eq("midrst_inst", 64'(out_inst), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(8);
        req_flag = 1'b1; req_addr = 32'h104; push_word(32'h104, cyc + 6);
        wait_flag("after_rst");
        req_flag = 1'b0;

        // Back-to-back: next request presented during the response cycle
        idle(2);
        req_flag = 1'b1; req_addr = 32'h0; push_word(32'h0, cyc + 6);
        wait_flag("b2b_first");
        req_addr = 32'h4; push_word(32'h4, cyc + 7);
        wait_flag("b2b_second");
        req_flag = 1'b0;

        // Misaligned request
        idle(2);
        req_flag = 1'b1; req_addr = 32'h102; push_word(32'h102, cyc + 6);
        wait_flag("misaligned");
        check_eq("mis_addr", 64'(out_addr), 64'h102);
        check_eq("mis_word", 64'(out_inst), 64'h00A00513);
        req_flag = 1'b0;

        idle(4);
        check_eq("issue_q_drained", 64'(issue_q.size()), 64'd0);
        check_eq("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
